// File: rtl/spi_xfer_arbiter_pkg.sv
// Shared types and width helpers for the SPI transfer arbiter and its picker.
package spi_arb_pkg;

   typedef enum logic [2:0] {
      StateIdle,
      StateLaunch,
      StateWaitBusy,
      StateWaitReady,
      StateResp
   } state_e;

   // Index width for n items, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Handshake between the arbiter (master) and the shared byte-exchange SPI engine (slave).
interface spi_xfer_arbiter_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  spi_exchange;
   logic [DATA_WIDTH-1:0] spi_send_data;
   logic                  spi_select;
   logic                  spi_busy;
   logic                  spi_ready;
   logic [DATA_WIDTH-1:0] spi_recv_data;

   modport master (
      output spi_exchange, spi_send_data, spi_select,
      input  spi_busy, spi_ready, spi_recv_data
   );

   modport slave (
      input  spi_exchange, spi_send_data, spi_select,
      output spi_busy, spi_ready, spi_recv_data
   );
endinterface

// File: rtl/spi_xfer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module spi_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  ireq,
   input  logic [IW-1:0] iptr,
   output logic [N-1:0]  ogrant,
   output logic [IW-1:0] oidx,
   output logic          ohit
);

   int j;

   always_comb begin
      ogrant = '0;
      oidx   = '0;
      ohit   = 1'b0;
      j      = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(iptr) + i) % N;
         if (!ohit && ireq[j]) begin
            ohit      = 1'b1;
            oidx      = IW'(j);
            ogrant[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one byte-exchange SPI engine among NUM_REQ requesters with per-burst round-robin,
// burst locking and a hang/abandon timeout.
//
// state          | meaning
// StateIdle      | pick a requester (owner only while locked); lock watchdog runs here
// StateLaunch    | owner registered, raise spi_exchange
// StateWaitBusy  | exchange requested, waiting for engine busy or ready
// StateWaitReady | engine shifting, waiting for ready
// StateResp      | oresp pulse out; update lock and rr pointer
module spi_xfer_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int REQ_ADDR       = idx_width(NUM_REQ),
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TO_WIDTH       = 12
) (
   input  logic                          iclk,
   input  logic                          irst_n,
   input  logic [NUM_REQ-1:0]            ireq,
   input  logic [NUM_REQ-1:0]            ilast,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] idata,
   input  logic [NUM_REQ-1:0]            isel,
   output logic [NUM_REQ-1:0]            ogrant,
   output logic [NUM_REQ-1:0]            oresp,
   output logic [DATA_WIDTH-1:0]         odata,
   output logic [NUM_REQ-1:0]            otimeout,
   output logic                          olocked,
   spi_xfer_arbiter_if.master            spi
);

   localparam logic [TO_WIDTH-1:0] TO_LOAD = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   state_e                state_q, state_d;
   logic [REQ_ADDR-1:0]   owner_q, owner_d;
   logic [REQ_ADDR-1:0]   ptr_q, ptr_d;
   logic                  last_q, last_d;
   logic                  lock_q, lock_d;
   logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [NUM_REQ-1:0]    resp_q, resp_d;
   logic [NUM_REQ-1:0]    timeout_q, timeout_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  exch_q, exch_d;
   logic [DATA_WIDTH-1:0] send_q, send_d;
   logic                  sel_q, sel_d;

   logic [NUM_REQ-1:0]    owner_oh;
   logic [REQ_ADDR-1:0]   next_ptr;
   logic [NUM_REQ-1:0]    cand;
   logic [NUM_REQ-1:0]    pick_grant;
   logic [REQ_ADDR-1:0]   pick_idx;
   logic                  pick_hit;
   logic                  cnt_tc;
   logic                  do_abort;

   always_comb begin
      owner_oh           = '0;
      owner_oh[owner_q]  = 1'b1;
      next_ptr = (owner_q == REQ_ADDR'(NUM_REQ - 1)) ? '0 : owner_q + REQ_ADDR'(1);
      // While a burst is locked only the owner may be picked; others wait.
      cand     = lock_q ? (ireq & owner_oh) : ireq;
      cnt_tc   = (cnt_q == '0);
   end

   spi_rr_pick #(
      .N  (NUM_REQ),
      .IW (REQ_ADDR)
   ) u_pick (
      .ireq   (cand),
      .iptr   (ptr_q),
      .ogrant (pick_grant),
      .oidx   (pick_idx),
      .ohit   (pick_hit)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      last_d    = last_q;
      lock_d    = lock_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      resp_d    = '0;
      timeout_d = '0;
      data_d    = data_q;
      exch_d    = exch_q;
      send_d    = send_q;
      sel_d     = sel_q;
      do_abort  = 1'b0;

      case (state_q)
         StateIdle: begin
            if (pick_hit) begin
               owner_d = pick_idx;
               send_d  = idata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
               sel_d   = isel[pick_idx];
               last_d  = ilast[pick_idx];
               grant_d = pick_grant;
               state_d = StateLaunch;
            end else if (lock_q) begin
               // Owner went quiet mid-burst: give up the lock after the timeout.
               if (cnt_tc) begin
                  lock_d    = 1'b0;
                  sel_d     = 1'b0;
                  timeout_d = owner_oh;
                  ptr_d     = next_ptr;
               end else begin
                  cnt_d = cnt_q - TO_WIDTH'(1);
               end
            end
         end

         StateLaunch: begin
            exch_d  = 1'b1;
            cnt_d   = TO_LOAD;
            state_d = StateWaitBusy;
         end

         StateWaitBusy: begin
            if (spi.spi_ready) begin
               exch_d  = 1'b0;
               data_d  = spi.spi_recv_data;
               resp_d  = owner_oh;
               state_d = StateResp;
            end else if (cnt_tc) begin
               do_abort = 1'b1;
            end else begin
               cnt_d = cnt_q - TO_WIDTH'(1);
               if (spi.spi_busy) begin
                  exch_d  = 1'b0;
                  state_d = StateWaitReady;
               end
            end
         end

         StateWaitReady: begin
            if (spi.spi_ready) begin
               data_d  = spi.spi_recv_data;
               resp_d  = owner_oh;
               state_d = StateResp;
            end else if (cnt_tc) begin
               do_abort = 1'b1;
            end else begin
               cnt_d = cnt_q - TO_WIDTH'(1);
            end
         end

         StateResp: begin
            grant_d = '0;
            state_d = StateIdle;
            if (last_q) begin
               lock_d = 1'b0;
               sel_d  = 1'b0;
               ptr_d  = next_ptr;
            end else begin
               lock_d = 1'b1;
               cnt_d  = TO_LOAD;
            end
         end

         default: state_d = StateIdle;
      endcase

      if (do_abort) begin
         exch_d    = 1'b0;
         timeout_d = owner_oh;
         grant_d   = '0;
         lock_d    = 1'b0;
         sel_d     = 1'b0;
         ptr_d     = next_ptr;
         state_d   = StateIdle;
      end
   end

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         state_q   <= StateIdle;
         owner_q   <= '0;
         ptr_q     <= '0;
         last_q    <= 1'b0;
         lock_q    <= 1'b0;
         cnt_q     <= '0;
         grant_q   <= '0;
         resp_q    <= '0;
         timeout_q <= '0;
         data_q    <= '0;
         exch_q    <= 1'b0;
         send_q    <= '0;
         sel_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         last_q    <= last_d;
         lock_q    <= lock_d;
         cnt_q     <= cnt_d;
         grant_q   <= grant_d;
         resp_q    <= resp_d;
         timeout_q <= timeout_d;
         data_q    <= data_d;
         exch_q    <= exch_d;
         send_q    <= send_d;
         sel_q     <= sel_d;
      end
   end

   assign ogrant            = grant_q;
   assign oresp             = resp_q;
   assign odata             = data_q;
   assign otimeout          = timeout_q;
   assign olocked           = lock_q;
   assign spi.spi_exchange  = exch_q;
   assign spi.spi_send_data = send_q;
   assign spi.spi_select    = sel_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench: expected grants/responses queued at stimulus time, checked as the arbiter emits them.
module tb_spi_xfer_arbiter;

   localparam int BUSY_LEN = 16;

   logic        iclk = 1'b0;
   logic        irst_n;
   logic [3:0]  ireq, ilast, isel;
   logic [31:0] idata;
   logic [3:0]  ogrant, oresp, otimeout;
   logic [7:0]  odata;
   logic        olocked;

   spi_xfer_arbiter_if #(.DATA_WIDTH(8)) spi ();

   spi_xfer_arbiter #(
      .NUM_REQ        (4),
      .REQ_ADDR       (2),
      .DATA_WIDTH     (8),
      .TIMEOUT_CYCLES (32),
      .TO_WIDTH       (5)
   ) dut (
      .iclk     (iclk),
      .irst_n   (irst_n),
      .ireq     (ireq),
      .ilast    (ilast),
      .idata    (idata),
      .isel     (isel),
      .ogrant   (ogrant),
      .oresp    (oresp),
      .odata    (odata),
      .otimeout (otimeout),
      .olocked  (olocked),
      .spi      (spi)
   );

   always #5 iclk = ~iclk;

   // kind: 0 = response, 1 = timeout, 2 = launch only (aborted by reset)
   typedef struct {
      int         kind;
      int         idx;
      logic [7:0] tx;
      logic [7:0] rx;
      logic       sel;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ev_cnt = 0;
   logic eng_hang = 1'b0;
   logic eng_same = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] oh(input int i);
      logic [3:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic push(input int kind, input int idx, input logic [7:0] tx, input logic sel);
      exp_t e;
      e.kind = kind;
      e.idx  = idx;
      e.tx   = tx;
      e.rx   = tx ^ 8'h99;
      e.sel  = sel;
      sb.push_back(e);
   endtask

   task automatic wait_events(input int target, input int budget);
      int n;
      n = 0;
      while (ev_cnt < target && n < budget) begin
         @(negedge iclk); #1;
         n++;
      end
      check_eq("event_seen", 32'(ev_cnt >= target), 1);
   endtask

   task automatic wait_exch(input logic level, input int budget);
      int n;
      n = 0;
      while (spi.spi_exchange !== level && n < budget) begin
         @(posedge iclk); #1;
         n++;
      end
      check_eq("exch_level", 32'(spi.spi_exchange), 32'(level));
   endtask

   task automatic do_reset();
      irst_n = 1'b0;
      ireq   = '0;
      @(posedge iclk); #1;
      irst_n = 1'b1;
      sb.delete();
   endtask

   // Engine model: echoes tx ^ 8'h99 after BUSY_LEN busy cycles.
   logic [7:0] eng_tx;
   int         eng_cnt;
   initial begin
      spi.spi_busy      = 1'b0;
      spi.spi_ready     = 1'b0;
      spi.spi_recv_data = '0;
      eng_tx  = '0;
      eng_cnt = 0;
      forever begin
         @(negedge iclk);
         if (!irst_n) begin
            spi.spi_busy  = 1'b0;
            spi.spi_ready = 1'b0;
            eng_cnt       = 0;
         end else if (spi.spi_ready) begin
            spi.spi_busy  = 1'b0;
            spi.spi_ready = 1'b0;
         end else if (spi.spi_busy) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               spi.spi_busy      = 1'b0;
               spi.spi_ready     = 1'b1;
               spi.spi_recv_data = eng_tx ^ 8'h99;
            end
         end else if (spi.spi_exchange && !eng_hang) begin
            if (eng_same) begin
               spi.spi_busy      = 1'b1;
               spi.spi_ready     = 1'b1;
               spi.spi_recv_data = spi.spi_send_data ^ 8'h99;
            end else begin
               spi.spi_busy = 1'b1;
               eng_cnt      = BUSY_LEN;
               eng_tx       = spi.spi_send_data;
            end
         end
      end
   end

   // Monitor: checks each launch and each oresp/otimeout against the scoreboard front.
   logic exch_prev = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge iclk);
         if (spi.spi_exchange && !exch_prev) begin
            check_eq("launch_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               check_eq("grant", 32'(ogrant), 32'(oh(sb[0].idx)));
               check_eq("tx_byte", 32'(spi.spi_send_data), 32'(sb[0].tx));
               check_eq("select", 32'(spi.spi_select), 32'(sb[0].sel));
            end
         end
         exch_prev = spi.spi_exchange;
         if (oresp != 0 || otimeout != 0) begin
            ev_cnt++;
            if (sb.size() == 0) begin
               check_eq("event_unexpected", {oresp, otimeout}, 0);
            end else begin
               e = sb.pop_front();
               if (e.kind == 1) begin
                  check_eq("timeout", 32'(otimeout), 32'(oh(e.idx)));
                  check_eq("resp_on_to", 32'(oresp), 0);
               end else begin
                  check_eq("resp", 32'(oresp), 32'(oh(e.idx)));
                  check_eq("to_on_resp", 32'(otimeout), 0);
                  check_eq("odata", 32'(odata), 32'(e.rx));
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_time_limit: got expired expected finish");
      $fatal(1);
   end

   initial begin
      int b;
      int lat;
      irst_n = 1'b0;
      ireq   = '0;
      ilast  = '0;
      isel   = '0;
      idata  = '0;
      repeat (3) @(posedge iclk);
      #1;
      check_eq("rst_outputs", {1'b0, ogrant, oresp, otimeout, odata, olocked,
                               spi.spi_exchange, spi.spi_send_data, spi.spi_select}, 0);
      irst_n = 1'b1;

      // Single request, latency to exchange
      isel  = 4'b0001;
      ilast = 4'b1111;
      idata = 32'h000000A5;
      push(0, 0, 8'hA5, 1'b1);
      b = ev_cnt;
      @(posedge iclk); #1;
      ireq = 4'b0001;
      lat = 0;
      while (!spi.spi_exchange && lat < 10) begin
         @(posedge iclk); #1;
         lat++;
      end
      check_eq("launch_latency", lat, 2);
      wait_events(b + 1, 100);
      ireq = '0;
      @(posedge iclk); #1;
      check_eq("unlocked_after_last", 32'(olocked), 0);
      check_eq("select_released", 32'(spi.spi_select), 0);

      // Fairness with everyone requesting
      do_reset();
      isel  = 4'b1010;
      idata = 32'h13121110;
      push(0, 0, 8'h10, 1'b0);
      push(0, 1, 8'h11, 1'b1);
      push(0, 2, 8'h12, 1'b0);
      push(0, 3, 8'h13, 1'b1);
      push(0, 0, 8'h10, 1'b0);
      b = ev_cnt;
      ireq = 4'b1111;
      wait_events(b + 5, 400);
      ireq = '0;
      repeat (4) @(posedge iclk);
      #1;
      check_eq("fair_sb_drained", sb.size(), 0);

      // Burst lock: req0 three bytes, req2 arrives after the first
      do_reset();
      isel  = 4'b0001;
      ilast = 4'b1110;
      idata = 32'h00C000B0;
      push(0, 0, 8'hB0, 1'b1);
      push(0, 0, 8'hB1, 1'b1);
      push(0, 0, 8'hB2, 1'b1);
      push(0, 2, 8'hC0, 1'b0);
      b = ev_cnt;
      ireq = 4'b0001;
      wait_events(b + 1, 100);
      idata = 32'h00C000B1;
      ireq  = 4'b0101;
      @(posedge iclk); #1;
      check_eq("locked_between", 32'(olocked), 1);
      check_eq("select_held", 32'(spi.spi_select), 1);
      wait_events(b + 2, 100);
      idata = 32'h00C000B2;
      ilast = 4'b1111;
      wait_events(b + 3, 100);
      ireq = 4'b0100;
      wait_events(b + 4, 100);
      ireq = '0;
      @(posedge iclk); #1;
      check_eq("burst_unlocked", 32'(olocked), 0);

      // Hung engine: timeout, then pointer moves on
      do_reset();
      isel     = 4'b0000;
      ilast    = 4'b1111;
      idata    = 32'h00002221;
      eng_hang = 1'b1;
      push(1, 0, 8'h21, 1'b0);
      push(0, 1, 8'h22, 1'b0);
      push(0, 0, 8'h21, 1'b0);
      b = ev_cnt;
      ireq = 4'b0011;
      wait_exch(1'b1, 10);
      lat = 0;
      while (otimeout == 0 && lat < 100) begin
         @(posedge iclk); #1;
         lat++;
      end
      check_eq("timeout_latency", lat, 32);
      check_eq("exch_dropped_on_to", 32'(spi.spi_exchange), 0);
      eng_hang = 1'b0;
      wait_events(b + 2, 100);
      ireq = 4'b0001;
      wait_events(b + 3, 100);
      ireq = '0;

      // Busy and ready in the same cycle
      do_reset();
      idata    = 32'h0000005A;
      isel     = 4'b0001;
      eng_same = 1'b1;
      push(0, 0, 8'h5A, 1'b1);
      b = ev_cnt;
      ireq = 4'b0001;
      wait_events(b + 1, 100);
      ireq = '0;
      eng_same = 1'b0;
      repeat (10) @(posedge iclk);
      #1;
      check_eq("single_resp", ev_cnt, b + 1);

      // Reset while waiting for ready, then pointer must be back at 0
      idata = 32'h00007700;
      push(2, 1, 8'h77, 1'b0);
      ireq = 4'b0010;
      wait_exch(1'b1, 10);
      wait_exch(1'b0, 10);
      repeat (3) @(posedge iclk);
      #1;
      irst_n = 1'b0;
      ireq   = '0;
      @(posedge iclk); #1;
      check_eq("midrst_outputs", {1'b0, ogrant, oresp, otimeout, odata, olocked,
                                  spi.spi_exchange, spi.spi_send_data, spi.spi_select}, 0);
      irst_n = 1'b1;
      sb.delete();
      b = ev_cnt;
      repeat (25) @(posedge iclk);
      #1;
      check_eq("no_resp_after_rst", ev_cnt, b);
      idata = 32'h00007766;
      push(0, 0, 8'h66, 1'b1);
      push(0, 1, 8'h77, 1'b0);
      ireq = 4'b0011;
      wait_events(b + 1, 100);
      ireq = 4'b0010;
      wait_events(b + 2, 100);
      ireq = '0;
      repeat (5) @(posedge iclk);
      #1;
      check_eq("final_sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
Shares one byte-exchange SPI engine among NUM_REQ requesters (e.g. bus-side FIFO controller, boot loader, flash poller). Round-robin arbitration per burst: a requester keeps the engine and its chip-select across multiple bytes until it flags the last byte. The block sequences the engine's exchange/busy/ready handshake, returns each received byte to the owner, and aborts hung exchanges with a timeout.

Parameters:
NUM_REQ, 4, number of requesters
REQ_ADDR, 2, log2(NUM_REQ), width of owner index
DATA_WIDTH, 8, SPI byte width
TIMEOUT_CYCLES, 4096, max iclk cycles spent in any wait state before abort
TO_WIDTH, 12, timeout counter width (2**TO_WIDTH >= TIMEOUT_CYCLES)

Ports:
iclk  in  1  system clock, all logic on rising edge
irst_n  in  1  synchronous reset, active low
ireq  in  NUM_REQ  per-requester byte-exchange request, level
ilast  in  NUM_REQ  byte is last of burst; release lock after it
idata  in  NUM_REQ*DATA_WIDTH  tx byte, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
isel  in  NUM_REQ  slave-select value per requester
ogrant  out  NUM_REQ  one-hot current owner
oresp  out  NUM_REQ  one-cycle pulse: owner's byte done, odata valid
odata  out  DATA_WIDTH  received byte, valid with oresp
otimeout  out  NUM_REQ  one-cycle pulse: owner's exchange aborted
olocked  out  1  burst lock held
spi_exchange  out  1  start request to engine
spi_send_data  out  DATA_WIDTH  byte to engine
spi_select  out  1  slave select to engine
spi_busy  in  1  engine shifting
spi_ready  in  1  engine finished, spi_recv_data valid
spi_recv_data  in  DATA_WIDTH  engine rx byte

Behaviour:
- Reset (irst_n=0 at edge): all outputs 0, FSM StateIdle, rr pointer 0, lock cleared, counter 0. Mid-operation reset drops spi_exchange next edge; no oresp/otimeout for the aborted byte.
- States: StateIdle, StateLaunch, StateWaitBusy, StateWaitReady, StateResp.
- StateIdle: locked -> candidate set = owner only; else round-robin search from pointer over ireq. On a hit, register owner, spi_send_data=idata[owner], spi_select=isel[owner], last flag=ilast[owner], ogrant one-hot -> StateLaunch. No hit: stay.
- StateLaunch: spi_exchange=1, -> StateWaitBusy. ireq->spi_exchange latency is exactly 2 cycles.
- StateWaitBusy: spi_busy=1 -> spi_exchange=0, -> StateWaitReady. spi_ready=1 (same cycle or alone) -> spi_exchange=0, capture spi_recv_data, -> StateResp.
- StateWaitReady: spi_ready=1 -> capture spi_recv_data into odata, -> StateResp.
- StateResp: oresp[owner]=1 for one cycle; ogrant cleared; if last flag -> lock cleared, pointer=(owner+1) mod NUM_REQ; else lock set (owner retained, pointer unchanged). -> StateIdle.
- Requester holds idata/ilast stable from ireq until oresp; ireq still high after oresp is a new byte (requester updates idata in the oresp cycle).
- Timeout: counter clears on entering StateWaitBusy, increments in StateWaitBusy/StateWaitReady; at TIMEOUT_CYCLES-1 without completion: spi_exchange=0, otimeout[owner] pulse, no oresp, lock cleared, pointer advanced, -> StateIdle.
- Lock watchdog: locked in StateIdle with owner's ireq low counts on same counter; at TIMEOUT_CYCLES-1 lock cleared, otimeout[owner] pulse.
- spi_select stays at owner's isel while locked and between bytes; returns 0 only when lock clears.
- Requests from non-owners while locked are held off, never dropped.

Decomposition:
- Package spi_arb_pkg: state encodings, REQ_ADDR/TO_WIDTH derivation helper.
- Sub-module spi_rr_pick: combinational round-robin picker (ireq mask, pointer -> one-hot grant + index); reused by future register-bus arbiters.

Test Plan:
- Single req: ireq=4'b0001, idata[0]=8'hA5, ilast=1; engine model busy 16 cycles, returns 8'h3C -> spi_exchange 2 cycles after ireq, spi_send_data=8'hA5, oresp=4'b0001 with odata=8'h3C, olocked=0.
- Fairness: ireq=4'b1111 constant, all ilast=1 -> grants 0,1,2,3,0 in order, one oresp each.
- Burst lock: req0 sends 3 bytes (ilast on 3rd) while req2 asserts after byte 1 -> bytes 0,0,0 then 2; spi_select held steady over req0's burst.
- Hung engine: TIMEOUT_CYCLES=32, spi_busy never rises -> otimeout[owner] pulses 32 cycles after launch, no oresp, next requester granted.
- busy+ready same cycle in StateWaitBusy -> single oresp, correct odata; reset asserted mid StateWaitReady -> all outputs 0 next edge, pointer 0.
